// File: rtl/modsq_job_sequencer.sv
// ---------------------------------------------------------------------------
// modsq_job_sequencer
//
// Purpose:
//   Sequences a repeated-squaring job for an external modular squarer.
//   A job carries an initial value and a squaring count. The sequencer
//   presents the value to the squarer, pulses a single start, and counts
//   iteration-done pulses. On the final pulse it captures the squarer's
//   redundant coefficients. It then carry-propagates them, one word per
//   cycle, into a normalized result. The result is held until it is
//   consumed.
//
// Ports:
//   clk        - sole clock
//   reset      - asynchronous, active-low reset
//   job_valid  - job offered
//   job_ready  - sequencer can take a job (IDLE only)
//   job_x      - initial value, MOD_LEN bits
//   job_t      - number of squarings, ITER_W bits (0 = pass job_x through)
//   sq_start   - one-cycle start pulse to the squarer
//   sq_in      - squarer operand, stable for the whole job
//   sq_out     - squarer coefficients, one lane per coefficient
//   sq_valid   - one-cycle pulse per finished squarer iteration
//   res_valid  - normalized result available (DONE only)
//   res_ready  - result consumer handshake
//   res_data   - normalized result, NUM_ELEMENTS words of WORD_LEN bits
//   res_carry  - carry out of the most significant word
//   busy       - sequencer is not idle
// ---------------------------------------------------------------------------
module modsq_job_sequencer #(
  parameter int MOD_LEN            = 1024,
  parameter int WORD_LEN           = 16,
  parameter int REDUNDANT_ELEMENTS = 2,
  parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
  parameter int SQ_OUT_BITS        = NUM_ELEMENTS * WORD_LEN * 2,
  parameter int ITER_W             = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             job_valid,
  output logic                             job_ready,
  input  logic [MOD_LEN-1:0]               job_x,
  input  logic [ITER_W-1:0]                job_t,
  output logic                             sq_start,
  output logic [MOD_LEN-1:0]               sq_in,
  input  logic [SQ_OUT_BITS-1:0]           sq_out,
  input  logic                             sq_valid,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [NUM_ELEMENTS*WORD_LEN-1:0] res_data,
  output logic [1:0]                       res_carry,
  output logic                             busy
);

  localparam int LANE_W  = SQ_OUT_BITS / NUM_ELEMENTS;
  localparam int COEFF_W = WORD_LEN + 1;
  localparam int RES_W   = NUM_ELEMENTS * WORD_LEN;
  localparam int IDX_W   = $clog2(NUM_ELEMENTS + 1);

  // The normalizer index runs one step past the last coefficient.
  // That extra step is where the final carry is published.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          r_state;
  logic [MOD_LEN-1:0]  r_sqIn;
  logic [ITER_W-1:0]   r_target;
  logic [ITER_W-1:0]   r_iterCnt;
  logic [COEFF_W-1:0]  r_coeff [NUM_ELEMENTS];
  logic [1:0]          r_carry;
  logic [IDX_W-1:0]    r_idx;
  logic [RES_W-1:0]    r_resData;
  logic [1:0]          r_resCarry;

  logic [ITER_W-1:0]   w_iterInc;
  logic                w_lastIter;
  logic [COEFF_W-1:0]  w_coeffSel;
  logic [WORD_LEN+1:0] w_acc;
  logic                w_unusedLaneBits;

  // The counter is only ever compared after incrementing.
  // A target of all-ones is therefore reached without wrapping.
  assign w_iterInc  = r_iterCnt + ITER_W'(1);
  assign w_lastIter = (w_iterInc == r_target);

  // Only the low WORD_LEN+1 bits of each lane carry information.
  // The rest of each lane is deliberately dropped.
  assign w_unusedLaneBits = ^sq_out;

  // Select the coefficient addressed by the normalizer index.
  // The out-of-range step past the last word reads as zero.
  always_comb begin
    w_coeffSel = '0;
    for (int k = 0; k < NUM_ELEMENTS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_coeffSel = r_coeff[k];
      end
    end
  end

  // One carry-propagate step.
  // Coefficient plus incoming carry can reach 2^(WORD_LEN+1)+2.
  // Two carry bits are therefore enough.
  assign w_acc = {1'b0, w_coeffSel} + {{WORD_LEN{1'b0}}, r_carry};

  // Job sequencing FSM plus all datapath registers it owns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_sqIn     <= '0;
      r_target   <= '0;
      r_iterCnt  <= '0;
      r_carry    <= '0;
      r_idx      <= '0;
      r_resData  <= '0;
      r_resCarry <= '0;
      for (int k = 0; k < NUM_ELEMENTS; k++) begin
        r_coeff[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            r_sqIn    <= job_x;
            r_target  <= job_t;
            r_iterCnt <= '0;
            if (job_t != '0) begin
              r_state <= S_START;
            end else begin
              // Zero squarings: the result is the operand itself.
              r_resData  <= RES_W'(job_x);
              r_resCarry <= '0;
              r_state    <= S_DONE;
            end
          end
        end

        S_START: begin
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (sq_valid) begin
            r_iterCnt <= w_iterInc;
            if (w_lastIter) begin
              for (int k = 0; k < NUM_ELEMENTS; k++) begin
                r_coeff[k] <= sq_out[k*LANE_W +: COEFF_W];
              end
              r_carry <= '0;
              r_idx   <= '0;
              r_state <= S_NORM;
            end
          end
        end

        S_NORM: begin
          if (r_idx == LAST_IDX) begin
            r_resCarry <= r_carry;
            r_state    <= S_DONE;
          end else begin
            for (int k = 0; k < NUM_ELEMENTS; k++) begin
              if (r_idx == IDX_W'(k)) begin
                r_resData[k*WORD_LEN +: WORD_LEN] <= w_acc[WORD_LEN-1:0];
              end
            end
            r_carry <= w_acc[WORD_LEN+1:WORD_LEN];
            r_idx   <= r_idx + IDX_W'(1);
          end
        end

        S_DONE: begin
          if (res_ready) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake and status outputs decode directly from the state register.
  assign job_ready = (r_state == S_IDLE);
  assign sq_start  = (r_state == S_START);
  assign res_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sq_in     = r_sqIn;
  assign res_data  = r_resData;
  assign res_carry = r_resCarry;

endmodule

// File: tb/tb_modsq_job_sequencer.sv
// ---------------------------------------------------------------------------
// tb_modsq_job_sequencer
//
// Purpose:
//   Self-checking bench for modsq_job_sequencer. A driver issues jobs and
//   emulates the squarer. Expected results, start-pulse counts and
//   res_valid rise cycles are queued. A monitor compares them whenever the
//   DUT presents a result. Reference results come from treating the
//   captured coefficients as one large integer, sum(c[k] * 2^(WORD_LEN*k)).
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_modsq_job_sequencer;

  localparam int MOD_LEN  = 64;
  localparam int WORD_LEN = 16;
  localparam int RED      = 2;
  localparam int N        = MOD_LEN / WORD_LEN + RED;
  localparam int SQ_W     = N * WORD_LEN * 2;
  localparam int LANE_W   = 32;
  localparam int ITER_W   = 32;
  localparam int RES_W    = N * WORD_LEN;

  logic                clk = 1'b0;
  logic                reset;
  logic                job_valid;
  logic                job_ready;
  logic [MOD_LEN-1:0]  job_x;
  logic [ITER_W-1:0]   job_t;
  logic                sq_start;
  logic [MOD_LEN-1:0]  sq_in;
  logic [SQ_W-1:0]     sq_out;
  logic                sq_valid;
  logic                res_valid;
  logic                res_ready;
  logic [RES_W-1:0]    res_data;
  logic [1:0]          res_carry;
  logic                busy;

  int nCompared   = 0;
  int nMismatched = 0;
  int cycleCount  = 0;

  logic [RES_W+1:0] expQ[$];
  int               expStartQ[$];
  int               riseQ[$];

  modsq_job_sequencer #(
    .MOD_LEN(MOD_LEN), .WORD_LEN(WORD_LEN), .REDUNDANT_ELEMENTS(RED),
    .NUM_ELEMENTS(N), .SQ_OUT_BITS(SQ_W), .ITER_W(ITER_W)
  ) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_x(job_x), .job_t(job_t),
    .sq_start(sq_start), .sq_in(sq_in), .sq_out(sq_out), .sq_valid(sq_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .busy(busy)
  );

  // Free-running clock and an edge counter used for latency expectations.
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  task automatic failNow(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: bounded wait expired, got nothing, expected an event (cycle %0d)", name, cycleCount);
  endtask

  // Reference: the coefficients form one big integer.
  // Its low RES_W bits are the data and the bits above are the carry.
  function automatic logic [RES_W+1:0] modelResult(input logic [MOD_LEN-1:0] x, input int t,
                                                   input logic [SQ_W-1:0] lanes);
    logic [127:0]      total;
    logic [WORD_LEN:0] c;
    if (t == 0) return {2'b00, RES_W'(x)};
    total = '0;
    for (int k = 0; k < N; k++) begin
      c = lanes[k*LANE_W +: WORD_LEN+1];
      total = total + (128'(c) << (WORD_LEN * k));
    end
    return total[RES_W+1:0];
  endfunction

  function automatic logic [SQ_W-1:0] randLanes();
    logic [SQ_W-1:0] r;
    for (int k = 0; k < N; k++) r[k*LANE_W +: LANE_W] = $urandom();
    return r;
  endfunction

  function automatic logic [SQ_W-1:0] constLanes(input logic [31:0] v);
    logic [SQ_W-1:0] r;
    for (int k = 0; k < N; k++) r[k*LANE_W +: LANE_W] = v;
    return r;
  endfunction

  // Monitor: compares every presented result against the scoreboard.
  // It also checks idle behaviour and sq_in stability.
  initial begin : monitor
    logic             prevValid;
    logic [RES_W+1:0] lastRes;
    logic [MOD_LEN-1:0] pendX;
    int               startCnt;
    int               expRise;
    int               expStarts;
    prevValid = 1'b0;
    lastRes   = '0;
    pendX     = '0;
    startCnt  = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        prevValid = 1'b0;
        lastRes   = '0;
        startCnt  = 0;
      end else begin
        if (busy) checkOutput("sq_in_hold", sq_in, pendX);
        if (job_valid && job_ready) pendX = job_x;
        if (sq_start) startCnt++;
        if (res_valid && !prevValid) begin
          if (riseQ.size() == 0) begin
            checkOutput("unexpected_res_valid", res_valid, 1'b0);
          end else begin
            expRise = riseQ.pop_front();
            checkOutput("res_valid_rise_cycle", cycleCount, expRise);
          end
        end
        if (res_valid) begin
          if (expQ.size() == 0) begin
            checkOutput("result_without_job", res_valid, 1'b0);
          end else begin
            checkOutput("result", {res_carry, res_data}, expQ[0]);
            if (res_ready) begin
              lastRes   = expQ.pop_front();
              expStarts = expStartQ.pop_front();
              checkOutput("sq_start_cycles", startCnt, expStarts);
              startCnt = 0;
            end
          end
        end
        if (!busy) begin
          checkOutput("idle_res_valid", res_valid, 1'b0);
          checkOutput("idle_sq_start", sq_start, 1'b0);
          checkOutput("idle_hold", {res_carry, res_data}, lastRes);
        end
        prevValid = res_valid;
      end
    end
  end

  task automatic strayPulse();
    @(posedge clk); #1;
    sq_out   = randLanes();
    sq_valid = 1'b1;
    @(posedge clk); #1;
    sq_valid = 1'b0;
  endtask

  task automatic issueJob(input logic [MOD_LEN-1:0] x, input int t, input logic [RES_W+1:0] expected,
                          input bit pushExp, output int acceptEdge);
    bit got;
    if (pushExp) begin
      expQ.push_back(expected);
      expStartQ.push_back((t > 0) ? 1 : 0);
    end
    @(posedge clk); #1;
    job_valid = 1'b1;
    job_x     = x;
    job_t     = ITER_W'(t);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (job_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) failNow("job_accept");
    @(posedge clk); #1;
    acceptEdge = cycleCount;
    job_valid  = 1'b0;
    if (pushExp && t == 0) riseQ.push_back(acceptEdge);
  endtask

  // Squarer emulation, entered just after the accepting edge (START cycle).
  task automatic feedSquarer(input int t, input logic [SQ_W-1:0] lanes, input bit strayStart, input bit strayNorm);
    int gap;
    if (strayStart) begin
      sq_out   = randLanes();
      sq_valid = 1'b1;
    end
    @(posedge clk); #1;
    sq_valid = 1'b0;
    for (int i = 1; i <= t; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      sq_out   = (i == t) ? lanes : randLanes();
      sq_valid = 1'b1;
      if (i == t) riseQ.push_back(cycleCount + 1 + N + 1);
      @(posedge clk); #1;
      sq_valid = 1'b0;
    end
    if (strayNorm) begin
      sq_out   = randLanes();
      sq_valid = 1'b1;
      @(posedge clk); #1;
      sq_valid = 1'b0;
    end
  endtask

  task automatic collectResult(input int delay);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) failNow("res_valid_wait");
    repeat (delay) @(posedge clk);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic applyStimulus(input logic [MOD_LEN-1:0] x, input int t, input logic [SQ_W-1:0] lanes,
                               input logic [RES_W+1:0] expected, input bit strayIdle,
                               input bit strayStart, input bit strayNorm, input int delay);
    int acc;
    if (strayIdle) strayPulse();
    issueJob(x, t, expected, 1'b1, acc);
    if (t > 0) feedSquarer(t, lanes, strayStart, strayNorm);
    collectResult(delay);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_sq_start"}, sq_start, 1'b0);
    checkOutput({tag, "_sq_in"}, sq_in, '0);
    checkOutput({tag, "_res_valid"}, res_valid, 1'b0);
    checkOutput({tag, "_res_data"}, res_data, '0);
    checkOutput({tag, "_res_carry"}, res_carry, 2'b00);
    checkOutput({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    logic [SQ_W-1:0]  lanes;
    logic [MOD_LEN-1:0] x;
    int               t;
    int               acc;
    reset     = 1'b0;
    job_valid = 1'b0;
    job_x     = '0;
    job_t     = '0;
    sq_out    = '0;
    sq_valid  = 1'b0;
    res_ready = 1'b0;

    #23;
    checkResetOutputs("reset");
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_job_ready", job_ready, 1'b1);

    $display("[TB] directed: unit coefficients");
    applyStimulus(64'd5, 3, constLanes(32'h0000_0001), {2'b00, {N{16'h0001}}}, 1'b0, 1'b0, 1'b0, 0);

    $display("[TB] directed: carry ripple, upper lane bits ignored");
    applyStimulus(64'd7, 2, constLanes(32'h0001_FFFF),
                  {2'b10, {(N-2){16'h0001}}, 16'h0000, 16'hFFFF}, 1'b0, 1'b0, 1'b0, 1);

    $display("[TB] directed: zero squarings");
    applyStimulus(64'h1234, 0, '0, {2'b00, RES_W'(64'h1234)}, 1'b0, 1'b0, 1'b0, 2);

    $display("[TB] directed: stray sq_valid in IDLE, START and NORM");
    lanes = randLanes();
    applyStimulus(64'hABCD, 3, lanes, modelResult(64'hABCD, 3, lanes), 1'b1, 1'b1, 1'b1, 0);
    applyStimulus(64'hABCD, 3, lanes, modelResult(64'hABCD, 3, lanes), 1'b0, 1'b0, 1'b0, 0);

    $display("[TB] directed: res_ready held low with a job waiting");
    lanes = randLanes();
    issueJob(64'h77, 1, modelResult(64'h77, 1, lanes), 1'b1, acc);
    feedSquarer(1, lanes, 1'b0, 1'b0);
    begin : waitDone
      bit got;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (res_valid) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) failNow("res_valid_wait_hold");
    end
    @(posedge clk); #1;
    job_valid = 1'b1;
    job_x     = 64'h55;
    job_t     = '0;
    expQ.push_back({2'b00, RES_W'(64'h55)});
    expStartQ.push_back(0);
    repeat (10) begin
      @(negedge clk);
      checkOutput("no_accept_in_done", job_ready, 1'b0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    riseQ.push_back(cycleCount + 1);
    @(negedge clk);
    checkOutput("bubble_busy", busy, 1'b0);
    checkOutput("bubble_job_ready", job_ready, 1'b1);
    @(posedge clk); #1;
    job_valid = 1'b0;
    collectResult(0);

    $display("[TB] directed: reset during WAIT");
    lanes = randLanes();
    issueJob(64'h99, 4, '0, 1'b0, acc);
    @(posedge clk); #1;
    sq_out   = lanes;
    sq_valid = 1'b1;
    @(posedge clk); #1;
    sq_valid = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    checkResetOutputs("abort");
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      sq_valid = 1'b1;
      @(posedge clk); #1;
      sq_valid = 1'b0;
    end
    repeat (20) @(negedge clk);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_job_ready", job_ready, 1'b1);
    checkOutput("abort_res_valid", res_valid, 1'b0);
    lanes = randLanes();
    applyStimulus(64'h42, 2, lanes, modelResult(64'h42, 2, lanes), 1'b0, 1'b0, 1'b0, 0);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 25; j++) begin
      x     = {$urandom(), $urandom()};
      t     = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
      lanes = randLanes();
      applyStimulus(x, t, lanes, modelResult(x, t, lanes), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    repeat (5) @(posedge clk);
    checkOutput("drain_results", expQ.size(), 0);
    checkOutput("drain_rises", riseQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
